// File: rtl/button_conditioner.sv
// WIDTH-channel button front end: synchroniser, symmetric debounce, press/release edges, long-press.
// Define AUTO_REPEAT_EN to enable the auto-repeat pulse train after long_press.
module button_conditioner #(
    parameter int WIDTH          = 4,
    parameter int SYNC_STAGES    = 2,
    parameter int SAMPLE_CNT_MAX = 50000,
    parameter int PULSE_CNT_MAX  = 200,
    parameter int LONG_CNT_MAX   = 2000,
    parameter int REPEAT_CNT_MAX = 400,
    parameter bit ACTIVE_LOW     = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_i,
    output logic [WIDTH-1:0] level_o,
    output logic [WIDTH-1:0] press_o,
    output logic [WIDTH-1:0] release_o,
    output logic [WIDTH-1:0] long_press_o,
    output logic [WIDTH-1:0] repeat_o
);

    localparam int TW = $clog2(SAMPLE_CNT_MAX + 1);
    localparam int DW = $clog2(PULSE_CNT_MAX + 1);
    localparam int HW = $clog2(LONG_CNT_MAX + 1);

    localparam logic [TW-1:0]    TICK_LAST  = TW'(SAMPLE_CNT_MAX - 1);
    localparam logic [DW-1:0]    PULSE_LAST = DW'(PULSE_CNT_MAX - 1);
    localparam logic [HW-1:0]    LONG_LAST  = HW'(LONG_CNT_MAX - 1);
    localparam logic [HW-1:0]    LONG_FULL  = HW'(LONG_CNT_MAX);
    localparam logic [WIDTH-1:0] IDLE_PINS  = ACTIVE_LOW ? {WIDTH{1'b1}} : {WIDTH{1'b0}};

    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] pressed_s;

    logic [TW-1:0]    tcnt_q, tcnt_d;
    logic             tick;

    logic [DW-1:0]    dcnt_q [WIDTH];
    logic [DW-1:0]    dcnt_d [WIDTH];
    logic [HW-1:0]    hcnt_q [WIDTH];
    logic [HW-1:0]    hcnt_d [WIDTH];

    logic [WIDTH-1:0] level_q, level_d;
    logic [WIDTH-1:0] press_q, press_d;
    logic [WIDTH-1:0] release_q, release_d;
    logic [WIDTH-1:0] long_q, long_d;

    // NOTE: the synchroniser array is small and must restart from the idle pin value, so unlike
    // a RAM it is reset explicitly; otherwise a stale pressed sample could survive rst.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= IDLE_PINS;
        end else begin
            sync_q[0] <= in_i;
            for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
        end
    end

    assign pressed_s = sync_q[SYNC_STAGES-1] ^ IDLE_PINS;
    assign tick      = (tcnt_q == TICK_LAST);

    // NOTE: every variable gets its default at the top of the block so no path can leave one
    // unassigned and infer a latch.
    always_comb begin
        tcnt_d    = tick ? '0 : tcnt_q + 1'b1;
        level_d   = level_q;
        press_d   = '0;
        release_d = '0;
        long_d    = '0;
        for (int ch = 0; ch < WIDTH; ch++) begin
            dcnt_d[ch] = dcnt_q[ch];
            hcnt_d[ch] = hcnt_q[ch];

            if (tick) begin
                if (pressed_s[ch] != level_q[ch]) begin
                    if (dcnt_q[ch] == PULSE_LAST) begin
                        dcnt_d[ch]    = '0;
                        level_d[ch]   = ~level_q[ch];
                        press_d[ch]   = ~level_q[ch];
                        release_d[ch] = level_q[ch];
                    end else begin
                        dcnt_d[ch] = dcnt_q[ch] + 1'b1;
                    end
                end else begin
                    dcnt_d[ch] = '0;
                end
            end

            // Hold time saturates at LONG_FULL, which is what keeps long_press to one pulse.
            if (!level_q[ch]) begin
                hcnt_d[ch] = '0;
            end else if (tick && hcnt_q[ch] != LONG_FULL) begin
                hcnt_d[ch] = hcnt_q[ch] + 1'b1;
                long_d[ch] = (hcnt_q[ch] == LONG_LAST);
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            tcnt_q    <= '0;
            level_q   <= '0;
            press_q   <= '0;
            release_q <= '0;
            long_q    <= '0;
            for (int ch = 0; ch < WIDTH; ch++) begin
                dcnt_q[ch] <= '0;
                hcnt_q[ch] <= '0;
            end
        end else begin
            tcnt_q    <= tcnt_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
            long_q    <= long_d;
            for (int ch = 0; ch < WIDTH; ch++) begin
                dcnt_q[ch] <= dcnt_d[ch];
                hcnt_q[ch] <= hcnt_d[ch];
            end
        end
    end

    assign level_o      = level_q;
    assign press_o      = press_q;
    assign release_o    = release_q;
    assign long_press_o = long_q;

`ifdef AUTO_REPEAT_EN
    localparam int RW = $clog2(REPEAT_CNT_MAX + 1);
    localparam logic [RW-1:0] REPEAT_LAST = RW'(REPEAT_CNT_MAX - 1);

    logic [RW-1:0]    rcnt_q [WIDTH];
    logic [RW-1:0]    rcnt_d [WIDTH];
    logic [WIDTH-1:0] repeat_q, repeat_d;

    // Repeat ticks only start once the hold counter has saturated, i.e. after long_press.
    always_comb begin
        repeat_d = '0;
        for (int ch = 0; ch < WIDTH; ch++) begin
            rcnt_d[ch] = rcnt_q[ch];
            if (!level_q[ch]) begin
                rcnt_d[ch] = '0;
            end else if (tick && hcnt_q[ch] == LONG_FULL) begin
                if (rcnt_q[ch] == REPEAT_LAST) begin
                    rcnt_d[ch]   = '0;
                    repeat_d[ch] = 1'b1;
                end else begin
                    rcnt_d[ch] = rcnt_q[ch] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            repeat_q <= '0;
            for (int ch = 0; ch < WIDTH; ch++) rcnt_q[ch] <= '0;
        end else begin
            repeat_q <= repeat_d;
            for (int ch = 0; ch < WIDTH; ch++) rcnt_q[ch] <= rcnt_d[ch];
        end
    end

    assign repeat_o = repeat_q;
`else
    assign repeat_o = '0;
`endif

endmodule

// File: tb/tb_button_conditioner.sv
// Scoreboard bench for button_conditioner: directed phases then random pin activity, checked
// against an arithmetic reference model; a second DUT runs ACTIVE_LOW=1 on the inverted pins.
module tb_button_conditioner;

    localparam int W  = 4;
    localparam int SS = 2;
    localparam int SC = 4;
    localparam int PC = 3;
    localparam int LC = 5;
    localparam int RC = 2;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [W-1:0] pins = '0;
    logic [W-1:0] pins_n;

    logic [W-1:0] level_a, press_a, release_a, long_a, rep_a;
    logic [W-1:0] level_b, press_b, release_b, long_b, rep_b;

    int checks = 0;
    int errors = 0;
    int edge_cnt = 0;
    int step_no = 0;

    assign pins_n = ~pins;

    always #5 clk = ~clk;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    button_conditioner #(
        .WIDTH(W), .SYNC_STAGES(SS), .SAMPLE_CNT_MAX(SC), .PULSE_CNT_MAX(PC),
        .LONG_CNT_MAX(LC), .REPEAT_CNT_MAX(RC), .ACTIVE_LOW(1'b0)
    ) dut_a (
        .clk(clk), .rst(rst), .in_i(pins),
        .level_o(level_a), .press_o(press_a), .release_o(release_a),
        .long_press_o(long_a), .repeat_o(rep_a)
    );

    button_conditioner #(
        .WIDTH(W), .SYNC_STAGES(SS), .SAMPLE_CNT_MAX(SC), .PULSE_CNT_MAX(PC),
        .LONG_CNT_MAX(LC), .REPEAT_CNT_MAX(RC), .ACTIVE_LOW(1'b1)
    ) dut_b (
        .clk(clk), .rst(rst), .in_i(pins_n),
        .level_o(level_b), .press_o(press_b), .release_o(release_b),
        .long_press_o(long_b), .repeat_o(rep_b)
    );

    typedef struct {
        int           cyc;
        logic [W-1:0] level;
        logic [W-1:0] press;
        logic [W-1:0] rel;
        logic [W-1:0] lng;
        logic [W-1:0] rep;
    } ev_t;

    ev_t sb[$];

    // Reference model state, in terms of "what has been observed" rather than registers.
    int           since_rst;
    logic [W-1:0] m_level;
    int           run_len [W];
    int           held_ticks [W];
    logic [W-1:0] hist[$];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h required %0h", name, edge_cnt, got, exp);
        end
    endtask

    function automatic logic [63:0] pack(input logic [W-1:0] l, input logic [W-1:0] p,
                                         input logic [W-1:0] r, input logic [W-1:0] lg,
                                         input logic [W-1:0] rp);
        return {44'b0, l, p, r, lg, rp};
    endfunction

    // Advance the model over the coming clock edge and queue any pulses it predicts.
    task automatic model_step(input logic r, input logic [W-1:0] p);
        ev_t          e;
        logic [W-1:0] s;
        logic [W-1:0] next_level;
        bit           tick;
        e.cyc   = edge_cnt + 1;
        e.press = '0;
        e.rel   = '0;
        e.lng   = '0;
        e.rep   = '0;
        if (r) begin
            since_rst = 0;
            m_level   = '0;
            hist.delete();
            for (int k = 0; k < SS; k++) hist.push_back('0);
            for (int ch = 0; ch < W; ch++) begin
                run_len[ch]    = 0;
                held_ticks[ch] = 0;
            end
        end else begin
            s = hist.pop_front();
            hist.push_back(p);
            since_rst++;
            tick = (since_rst % SC == 0);
            next_level = m_level;
            for (int ch = 0; ch < W; ch++) begin
                if (!m_level[ch]) held_ticks[ch] = 0;
                if (tick) begin
                    if (m_level[ch]) begin
                        held_ticks[ch]++;
                        if (held_ticks[ch] == LC) e.lng[ch] = 1'b1;
`ifdef AUTO_REPEAT_EN
                        if (held_ticks[ch] > LC && (held_ticks[ch] - LC) % RC == 0) e.rep[ch] = 1'b1;
`endif
                    end
                    if (s[ch] != m_level[ch]) begin
                        run_len[ch]++;
                        if (run_len[ch] == PC) begin
                            run_len[ch]    = 0;
                            next_level[ch] = ~m_level[ch];
                            e.press[ch]    = ~m_level[ch];
                            e.rel[ch]      = m_level[ch];
                        end
                    end else begin
                        run_len[ch] = 0;
                    end
                end
            end
            m_level = next_level;
        end
        e.level = m_level;
        if (|{e.press, e.rel, e.lng, e.rep}) sb.push_back(e);
    endtask

    task automatic step(input logic r, input logic [W-1:0] p);
        rst  = r;
        pins = p;
        model_step(r, p);
        @(posedge clk);
        #1;
        step_no++;
        if (step_no % 16 == 0) begin
            check("level_a", level_a, m_level);
            check("level_b", level_b, m_level);
        end
    endtask

    // Monitor: pops one expected record whenever either DUT pulses or an expectation falls due.
    always @(negedge clk) begin
        logic a_evt, b_evt;
        ev_t  e;
        a_evt = |{press_a, release_a, long_a, rep_a};
        b_evt = |{press_b, release_b, long_b, rep_b};
        if (a_evt === 1'b1 || b_evt === 1'b1 || (sb.size() > 0 && sb[0].cyc <= edge_cnt)) begin
            if (sb.size() == 0 || sb[0].cyc > edge_cnt) begin
                check("unexpected_event", {62'b0, a_evt, b_evt}, 64'd0);
            end else begin
                e = sb.pop_front();
                check("event_cycle", edge_cnt, e.cyc);
                check("events_a", pack(level_a, press_a, release_a, long_a, rep_a),
                      pack(e.level, e.press, e.rel, e.lng, e.rep));
                check("events_b", pack(level_b, press_b, release_b, long_b, rep_b),
                      pack(e.level, e.press, e.rel, e.lng, e.rep));
            end
        end
    end

    initial begin
        logic [W-1:0] p;
        int           rate [W];

        repeat (3) step(1'b1, 4'b0001);
        check("reset_a", pack(level_a, press_a, release_a, long_a, rep_a), 64'd0);
        check("reset_b", pack(level_b, press_b, release_b, long_b, rep_b), 64'd0);

        // Channel 0 held from reset release.
        repeat (20) step(1'b0, 4'b0001);
        // Channel 1: two ticks high, one low, then high.
        repeat (8)  step(1'b0, 4'b0011);
        repeat (4)  step(1'b0, 4'b0001);
        repeat (20) step(1'b0, 4'b0011);
        // Channel 2: press, short low glitch, then a real release.
        repeat (20) step(1'b0, 4'b0101);
        repeat (8)  step(1'b0, 4'b0001);
        repeat (8)  step(1'b0, 4'b0101);
        repeat (20) step(1'b0, 4'b0001);
        // Channel 3: long hold with long_press and repeats, then release.
        repeat (70) step(1'b0, 4'b1001);
        repeat (20) step(1'b0, 4'b0001);
        // Reset mid-hold on channel 0.
        step(1'b1, 4'b0001);
        check("midreset_a", pack(level_a, press_a, release_a, long_a, rep_a), 64'd0);
        check("midreset_b", pack(level_b, press_b, release_b, long_b, rep_b), 64'd0);
        repeat (20) step(1'b0, 4'b0001);
        // All channels together.
        repeat (24) step(1'b0, 4'b0000);
        repeat (25) step(1'b0, 4'b1111);
        repeat (25) step(1'b0, 4'b0000);

        // Random activity with per-block toggle rates from bouncy to steady.
        p = '0;
        for (int blk = 0; blk < 15; blk++) begin
            for (int ch = 0; ch < W; ch++) begin
                case ($urandom_range(0, 2))
                    0:       rate[ch] = 4;
                    1:       rate[ch] = 30;
                    default: rate[ch] = 120;
                endcase
            end
            for (int c = 0; c < 200; c++) begin
                for (int ch = 0; ch < W; ch++)
                    if ($urandom_range(0, rate[ch] - 1) == 0) p[ch] = ~p[ch];
                step($urandom_range(0, 499) == 0, p);
            end
        end

        repeat (40) step(1'b0, 4'b0000);
        @(negedge clk);
        #1;
        check("scoreboard_drained", sb.size(), 64'd0);
        check("final_level_a", level_a, m_level);
        check("final_level_b", level_b, m_level);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
